cache_ctrl_fsm: RTL

- Sequencing controller for the 2-way set-associative, write-back, write-allocate cache in the virtual-memory subsystem.
- Waits for TLB translation to finish, then performs the tag compare.
- Owns the tag, valid, dirty and LRU metadata, and drives the cache data-array strobes.
- Runs word-serial writeback and refill bursts to main memory over a req/ack handshake.

---
 rtl/cache_ctrl_fsm.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/cache_ctrl_fsm.sv
// Sequencing controller for a 2-way write-back, write-allocate cache: TLB wait, tag compare,
// word-serial writeback/refill bursts; owns tag/valid/dirty/LRU state. Hit: ready 3 cycles after request.
module cache_ctrl_fsm #(
  parameter int ADDR_W   = 10,
  parameter int INDEX_W  = 2,
  parameter int OFFSET_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_write,
  input  logic [ADDR_W-1:0]   cpu_address,
  input  logic                tlb_end,
  output logic                cpu_ready,
  output logic                cpu_hit,
  output logic                busy,
  output logic                da_way,
  output logic [INDEX_W-1:0]  da_index,
  output logic [OFFSET_W-1:0] da_word,
  output logic                da_we,
  output logic                da_sel_mem,
  output logic                mem_req,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int SETS  = 1 << INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_TLB_WAIT, S_COMPARE, S_WBACK, S_FILL, S_DONE
  } state_t;

  state_t                             state_q;
  logic                               write_q;
  logic [ADDR_W-1:0]                  addr_q;
  logic                               first_miss_q;
  logic                               victim_q;
  logic [OFFSET_W-1:0]                cnt_q;
  logic                               cpu_ready_q;
  logic                               cpu_hit_q;
  logic                               busy_q;
  logic                               mem_req_q;
  logic                               mem_write_q;
  logic [1:0][SETS-1:0][TAG_W-1:0]    tag_q;
  logic [1:0][SETS-1:0]               valid_q;
  logic [1:0][SETS-1:0]               dirty_q;
  logic [SETS-1:0]                    lru_q;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  idx;
  logic [OFFSET_W-1:0] off;
  logic                hit0, hit1, hit;
  logic                victim_d;
  logic                last_beat;

  assign req_tag   = addr_q[ADDR_W-1 -: TAG_W];
  assign idx       = addr_q[OFFSET_W +: INDEX_W];
  assign off       = addr_q[OFFSET_W-1:0];
  assign hit0      = valid_q[0][idx] && (tag_q[0][idx] == req_tag);
  assign hit1      = valid_q[1][idx] && (tag_q[1][idx] == req_tag);
  assign hit       = hit0 | hit1;
  // Invalid ways are filled before any valid block is evicted.
  assign victim_d  = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);
  assign last_beat = mem_ack && (cnt_q == {OFFSET_W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      addr_q       <= '0;
      first_miss_q <= 1'b0;
      victim_q     <= 1'b0;
      cnt_q        <= '0;
      cpu_ready_q  <= 1'b0;
      cpu_hit_q    <= 1'b0;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      tag_q        <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      lru_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_req) begin
            write_q      <= cpu_write;
            addr_q       <= cpu_address;
            first_miss_q <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= S_TLB_WAIT;
          end
        end
        S_TLB_WAIT: begin
          if (tlb_end) state_q <= S_COMPARE;
        end
        S_COMPARE: begin
          if (hit) begin
            if (write_q) dirty_q[hit1][idx] <= 1'b1;
            lru_q[idx]  <= ~hit1;
            cpu_ready_q <= 1'b1;
            cpu_hit_q   <= ~first_miss_q;
            state_q     <= S_DONE;
          end else begin
            first_miss_q <= 1'b1;
            victim_q     <= victim_d;
            cnt_q        <= '0;
            mem_req_q    <= 1'b1;
            if (valid_q[victim_d][idx] && dirty_q[victim_d][idx]) begin
              mem_write_q <= 1'b1;
              state_q     <= S_WBACK;
            end else begin
              mem_write_q <= 1'b0;
              state_q     <= S_FILL;
            end
          end
        end
        S_WBACK: begin
          if (mem_ack) cnt_q <= cnt_q + 1'b1;
          if (last_beat) begin
            dirty_q[victim_q][idx] <= 1'b0;
            mem_write_q            <= 1'b0;
            state_q                <= S_FILL;
          end
        end
        S_FILL: begin
          if (mem_ack) cnt_q <= cnt_q + 1'b1;
          // Re-compare after the refill performs any pending write.
          if (last_beat) begin
            tag_q[victim_q][idx]   <= req_tag;
            valid_q[victim_q][idx] <= 1'b1;
            dirty_q[victim_q][idx] <= 1'b0;
            mem_req_q              <= 1'b0;
            state_q                <= S_COMPARE;
          end
        end
        S_DONE: begin
          cpu_ready_q <= 1'b0;
          cpu_hit_q   <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    da_way     = 1'b0;
    da_index   = '0;
    da_word    = '0;
    da_we      = 1'b0;
    da_sel_mem = 1'b0;
    mem_addr   = '0;
    case (state_q)
      S_COMPARE: begin
        da_way   = hit1;
        da_index = idx;
        da_word  = off;
        da_we    = hit & write_q;
      end
      S_WBACK: begin
        da_way   = victim_q;
        da_index = idx;
        da_word  = cnt_q;
        mem_addr = {tag_q[victim_q][idx], idx, cnt_q};
      end
      S_FILL: begin
        da_way     = victim_q;
        da_index   = idx;
        da_word    = cnt_q;
        da_we      = mem_ack;
        da_sel_mem = mem_ack;
        mem_addr   = {req_tag, idx, cnt_q};
      end
      default: ;
    endcase
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_hit   = cpu_hit_q;
  assign busy      = busy_q;
  assign mem_req   = mem_req_q;
  assign mem_write = mem_write_q;

endmodule
